// File: rtl/riscv_pkg.sv
// riscv_pkg: shared rv32i pipeline types for the memory stage and its registers.
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic            RegWrite;
    logic            MemWrite;
    logic [1:0]      ResultSrc;
    logic [4:0]      Rd;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] WriteData;
    logic [XLEN-1:0] PCPlus4;
  } ex_mem_s;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic [4:0]      Rd;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] ReadData;
    logic [XLEN-1:0] PCPlus4;
  } mem_wb_s;

  typedef enum logic [0:0] {
    MEM_IDLE      = 1'b0,
    MEM_WAIT_RESP = 1'b1
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with load enable and synchronous reset.
`default_nettype none

module ex_mem_reg
  import riscv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  ex_mem_s d,
  output ex_mem_s q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: rv32i memory stage; EX/MEM register, req/gnt/rvalid word access FSM,
// stall generation, busy watchdog and MEM/WB register.
`default_nettype none

module mem_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN    = riscv_pkg::XLEN,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            RegWriteM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic            MemBusyM,
  output logic            MemTimeoutM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W
);

  ex_mem_s    ex_in, exm;
  mem_wb_s    wb;
  mem_state_e state, state_next;
  logic       is_load, mem_op, done, busy, req;

  assign ex_in = '{RegWrite: RegWriteE, MemWrite: MemWriteE, ResultSrc: ResultSrcE,
                   Rd: RdE, ALUResult: ALUResultE, WriteData: WriteDataE,
                   PCPlus4: PCPlus4E};

  // EX/MEM only advances when the current access has finished
  ex_mem_reg u_ex_mem_reg (
    .clk (clk),
    .rst (rst),
    .en  (!busy),
    .d   (ex_in),
    .q   (exm)
  );

  assign is_load = (exm.ResultSrc == RES_MEM);
  assign mem_op  = exm.MemWrite | is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    done       = 1'b0;
    case (state)
      MEM_IDLE: begin
        req = mem_op;
        if (mem_op && dmem_gnt) begin
          if (exm.MemWrite || dmem_rvalid) begin
            done = 1'b1;
          end else begin
            state_next = MEM_WAIT_RESP;
          end
        end
      end
      MEM_WAIT_RESP: begin
        if (dmem_rvalid) begin
          done       = 1'b1;
          state_next = MEM_IDLE;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  assign busy = mem_op & ~done;

  // A busy cycle pushes a bubble into MEM/WB
  always_ff @(posedge clk) begin
    if (rst || busy) begin
      wb <= '0;
    end else begin
      wb <= '{RegWrite: exm.RegWrite, ResultSrc: exm.ResultSrc, Rd: exm.Rd,
              ALUResult: exm.ALUResult,
              ReadData: is_load ? dmem_rdata : '0,
              PCPlus4: exm.PCPlus4};
    end
  end

  generate
    if (TIMEOUT != 0) begin : g_wdog
      localparam int         CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIM  = CW'(TIMEOUT);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      logic [CW-1:0] cnt;
      logic          flag;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt  <= '0;
          flag <= 1'b0;
        end else begin
          if (!busy) begin
            cnt <= '0;
          end else if (cnt != LIM) begin
            cnt <= cnt + 1'b1;
          end
          if (busy && (cnt >= LAST)) begin
            flag <= 1'b1;
          end
        end
      end
      assign MemTimeoutM = flag;
    end else begin : g_no_wdog
      assign MemTimeoutM = 1'b0;
    end
  endgenerate

  assign RegWriteM  = exm.RegWrite;
  assign RdM        = exm.Rd;
  assign ALUResultM = exm.ALUResult;
  assign MemBusyM   = busy;
  assign dmem_req   = req;
  assign dmem_we    = exm.MemWrite;
  assign dmem_addr  = {exm.ALUResult[XLEN-1:2], 2'b00};
  assign dmem_wdata = exm.WriteData;

  assign RegWriteW  = wb.RegWrite;
  assign ResultSrcW = wb.ResultSrc;
  assign RdW        = wb.Rd;
  assign ALUResultW = wb.ALUResult;
  assign ReadDataW  = wb.ReadData;
  assign PCPlus4W   = wb.PCPlus4;

endmodule

`default_nettype wire
